imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side companion to the fetch stage: streams a program into instruction memory over a
//  valid/ready byte interface, then releases the core.
//  Drives the IMem write port and holds the core (core_hold) until a complete, valid image is loaded.
//  Sits between the host/boot byte source and IMem, beside the fetch stage.
// PARAMETERS
//  ADDR_W  8    IMem address width (8-bit PC)
//  DATA_W  8    instruction/byte width
//  DEPTH   256  IMem entries; must be <= 2**ADDR_W
// PORTS
//  clk        in   1         clock, rising edge
//  reset      in   1         asynchronous, active-low
//  start      in   1         1-cycle pulse: begin load of load_len bytes at address 0
//  load_len   in   ADDR_W+1  image length in bytes; sampled on start; legal range 1..DEPTH
//  abort      in   1         cancel load in progress
//  in_valid   in   1         source byte valid
//  in_data    in   DATA_W    source byte
//  in_ready   out  1         loader accepts byte this cycle
//  mem_we     out  1         IMem write enable
//  mem_addr   out  ADDR_W    IMem write address
//  mem_wdata  out  DATA_W    IMem write data
//  busy       out  1         load in progress (LOAD or CHECK)
//  done       out  1         1-cycle pulse: image complete and accepted
//  err        out  1         1-cycle pulse: bad length, abort, or checksum mismatch
//  core_hold  out  1         1 = fetch/PC held; 0 = core may run
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE.
//    Outputs: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, core_hold=1.
//    IMem contents are untouched.
//  - Reset mid-load: same as above. The partial image stays in IMem and core_hold stays 1.
//  - States: IDLE, LOAD, CHECK (only with CHECKSUM_EN), FIN.
//  - IDLE: in_ready=0.
//    - start with load_len==0 or load_len>DEPTH: err=1 next cycle; stay IDLE; core_hold unchanged.
//    - Legal start: latch len; cnt=0; core_hold=1; next state LOAD.
//  - LOAD: in_ready=1, busy=1.
//    - Handshake = in_valid & in_ready.
//    - Each handshake: next cycle mem_we=1, mem_addr=cnt, mem_wdata=in_data (1-cycle write latency).
//      Then cnt++.
//    - Handshake with cnt==len-1: next state CHECK (with CHECKSUM_EN) or FIN.
//    - in_ready=0 in the cycle after the last data byte.
//    - mem_we is 1 only in cycles following a handshake; no write without a handshake.
//    - cnt is ADDR_W+1 wide. Address wrap is impossible because len<=DEPTH.
//  - FIN: one cycle; done=1, core_hold=0, busy=0; then IDLE. The final mem_we coincides with FIN.
//  - abort in LOAD/CHECK: next cycle err=1, state IDLE, core_hold=1.
//    - Any pending final write still completes.
//    - abort takes priority over a same-cycle handshake; that byte is not written.
//  - start while busy: ignored. abort while IDLE: ignored.
//  - Simultaneous start & abort in IDLE: start wins.
//  - done and err are never both 1.
// CONFIGURATION
//  - Macro IMEM_LOADER_CHECKSUM_EN defined:
//    - Running sum = sum of data bytes mod 2**DATA_W.
//    - After the last data byte, CHECK accepts one extra byte (in_ready=1); it is not written to IMem.
//    - (sum + byte) mod 256 == 0: FIN (done, release).
//    - Otherwise: err=1, core_hold stays 1, then IDLE.
//  - Macro undefined: no CHECK state, no sum register; LOAD goes directly to FIN.
// STRUCTURE
//  - Shared package proc8_pkg:
//    - ADDR_W, DATA_W, DEPTH constants.
//    - Loader state encoding (IDLE=2'd0, LOAD=2'd1, CHECK=2'd2, FIN=2'd3).
//  - Single module; no sub-module. FSM, counter, write register and checksum accumulator are inline.
// TESTING
//  1. Reset held low 3 cycles, release.
//     -> core_hold=1, in_ready=0, mem_we=0, done=0, err=0.
//  2. start, load_len=4; bytes 8'h11,22,33,44 with continuous in_valid.
//     -> writes addr 0..3 with those bytes, one per cycle, each 1 cycle after handshake.
//     -> done pulse; core_hold=0 (checksum off).
//  3. Same as 2 with in_valid toggled 1/0.
//     -> exactly 4 writes, no write in idle cycles, same data.
//  4. start with load_len=0, then load_len=257.
//     -> err pulse each time; no mem_we; state stays IDLE.
//  5. load_len=256, abort asserted on byte 100 handshake.
//     -> addr 0..99 written, byte 100 not written, err pulse, core_hold=1.
//  6. CHECKSUM_EN: bytes 01,02,03 then FA -> done, core_hold=0.
//     Repeat with FB -> err, core_hold=1. The checksum byte is never written.

Source files
------------

// File: rtl/proc8_pkg.sv
// Shared constants and loader state encoding for the 8-bit processor slice.
package proc8_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 256;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StCheck = 2'd2,
        StFin   = 2'd3
    } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Streams a program image into IMem over a valid/ready byte port and holds the core until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum byte before releasing the core.
module imem_loader
    import proc8_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              core_hold
);

    loader_state_e     state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              err_q, err_d;
    logic              core_hold_q, core_hold_d;
    logic              hs;
    logic              len_bad;
    logic              last_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] sum_final;
`endif

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = 1'b0;
        core_hold_d = core_hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
        sum_final   = sum_q + in_data;
`endif
        in_ready  = (state_q == StLoad) || (state_q == StCheck);
        hs        = in_valid & in_ready;
        len_bad   = (load_len == '0) || (load_len > (ADDR_W + 1)'(DEPTH));
        last_byte = (cnt_q == len_q - 1'b1);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (len_bad) begin
                        err_d = 1'b1;
                    end else begin
                        len_d       = load_len;
                        cnt_d       = '0;
                        core_hold_d = 1'b1;
                        state_d     = StLoad;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d       = '0;
`endif
                    end
                end
            end
            StLoad: begin
                // abort wins over a same-cycle handshake: that byte is dropped
                if (abort) begin
                    err_d       = 1'b1;
                    core_hold_d = 1'b1;
                    state_d     = StIdle;
                end else if (hs) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q[ADDR_W-1:0];
                    mem_wdata_d = in_data;
                    cnt_d       = cnt_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d       = sum_final;
                    if (last_byte) begin
                        state_d = StCheck;
                    end
`else
                    if (last_byte) begin
                        state_d     = StFin;
                        core_hold_d = 1'b0;
                    end
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StCheck: begin
                if (abort) begin
                    err_d       = 1'b1;
                    core_hold_d = 1'b1;
                    state_d     = StIdle;
                end else if (hs) begin
                    if (sum_final == '0) begin
                        state_d     = StFin;
                        core_hold_d = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
`endif
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            len_q       <= '0;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            core_hold_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            core_hold_q <= core_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = in_ready;
    assign done      = (state_q == StFin);
    assign err       = err_q;
    assign core_hold = core_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; expected writes, pulses and hold state
// come from an image-level model built from the stimulus.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CkEn = 1'b1;
`else
    localparam bit CkEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [8:0] load_len = '0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, mem_we, busy, done, err, core_hold;
    logic [7:0] mem_addr, mem_wdata;

    imem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .load_len  (load_len),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .core_hold (core_hold)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    logic [47:0] act_wq[$];
    logic [47:0] exp_wq[$];
    logic [7:0]  img[256];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: log every IMem write with the cycle it lands in, and count pulses
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) act_wq.push_back({cyc, mem_addr, mem_wdata});
        if (done) done_cnt <= done_cnt + 1;
        if (err) err_cnt <= err_cnt + 1;
        if (done || err) check_eq("done_err_excl", {62'd0, done, err} & {62'd0, err, done}, 0);
    end

    task automatic cmp_writes(input string tag);
        check_eq({tag, "_nwr"}, act_wq.size(), exp_wq.size());
        for (int i = 0; i < exp_wq.size() && i < act_wq.size(); i++)
            check_eq({tag, "_wr"}, act_wq[i], exp_wq[i]);
        act_wq.delete();
        exp_wq.delete();
    endtask

    // Drive one byte; wait (bounded) for in_ready; returns 0 on timeout
    task automatic send_byte(input logic [7:0] b, input bit ab, input bit record,
                             input logic [7:0] addr, output bit ok);
        int t = 0;
        in_valid = 1'b1;
        in_data  = b;
        abort    = ab;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        ok = in_ready;
        if (!ok) check_eq("ready_timeout", 0, 1);
        else if (record && !ab) exp_wq.push_back({cyc + 32'd1, addr, b});
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b0;
    endtask

    // Load img[0..n-1]; abort on byte abort_at (>= n means none); checksum byte offset by ck_delta
    task automatic run_load(input string tag, input int n, input bit gappy, input int abort_at,
                            input logic [7:0] ck_delta);
        int         d0 = done_cnt;
        int         e0 = err_cnt;
        logic [7:0] sum = 8'd0;
        logic [7:0] ck;
        bit         aborted = 1'b0;
        bit         ok_img;
        bit         ok;
        start    = 1'b1;
        load_len = 9'(n);
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_busy"}, {63'd0, busy}, 1);
        for (int i = 0; i < n; i++) begin
            if (gappy) repeat (1 + $urandom_range(0, 2)) @(negedge clk);
            send_byte(img[i], (i == abort_at), 1'b1, 8'(i), ok);
            if (!ok) break;
            sum = sum + img[i];
            if (i == abort_at) begin
                aborted = 1'b1;
                break;
            end
        end
        ck = 8'(8'd0 - sum) + ck_delta;
        if (CkEn && !aborted) send_byte(ck, 1'b0, 1'b0, 8'd0, ok);
        repeat (4) @(negedge clk);
        ok_img = !aborted && (!CkEn || ck_delta == 8'd0);
        cmp_writes(tag);
        check_eq({tag, "_done"}, done_cnt - d0, ok_img ? 1 : 0);
        check_eq({tag, "_err"}, err_cnt - e0, ok_img ? 0 : 1);
        check_eq({tag, "_hold"}, {63'd0, core_hold}, ok_img ? 0 : 1);
        check_eq({tag, "_idle"}, {62'd0, in_ready, busy}, 0);
    endtask

    task automatic bad_start(input string tag, input int len);
        int d0 = done_cnt;
        int e0 = err_cnt;
        logic hold0 = core_hold;
        start    = 1'b1;
        load_len = 9'(len);
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_rdy"}, {63'd0, in_ready}, 0);
        repeat (3) @(negedge clk);
        check_eq({tag, "_err"}, err_cnt - e0, 1);
        check_eq({tag, "_done"}, done_cnt - d0, 0);
        check_eq({tag, "_hold"}, {63'd0, core_hold}, {63'd0, hold0});
        check_eq({tag, "_nwr"}, act_wq.size(), 0);
        act_wq.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_hold", {63'd0, core_hold}, 1);
        check_eq("rst_outs", {58'd0, in_ready, mem_we, busy, done, err, 1'b0}, 0);
        check_eq("rst_addr_data", {48'd0, mem_addr, mem_wdata}, 0);

        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
        run_load("t2", 4, 1'b0, 999, 8'd0);
        run_load("t3", 4, 1'b1, 999, 8'd0);

        bad_start("len0", 0);
        bad_start("len257", 257);

        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        run_load("abort100", 256, 1'b0, 100, 8'd0);

        // Full-depth boundary load
        run_load("full256", 256, 1'b0, 999, 8'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03;
        run_load("ck_ok", 3, 1'b0, 999, 8'd0);   // checksum byte FA
        run_load("ck_bad", 3, 1'b0, 999, 8'd1);  // checksum byte FB
`endif

        for (int r = 0; r < 8; r++) begin
            int n = $urandom_range(1, 40);
            int ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : 999;
            logic [7:0] dl = (CkEn && $urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            for (int i = 0; i < n; i++) img[i] = 8'($urandom);
            run_load("rnd", n, 1'($urandom_range(0, 1)), ab, dl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
